lsu_arbiter: RTL and testbench

- Two-master arbiter that shares the single load/store unit port (data memory plus output and input peripherals) between requester 0 (core datapath) and requester 1 (debug/DMA loader).
- Sits directly in front of the LSU and drives its addr, w_data, wr_en, bmask and ld_sel inputs.
- Round-robin arbitration, with an optional lock that gives a master an atomic read-modify-write sequence.
- Registered read return: one transaction per cycle per owner.

---
 rtl/lsu_arbiter.sv | 177 +++++++++++++++++
 tb/tb_lsu_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_arbiter.sv
// Two-master round-robin arbiter in front of the load/store unit, with optional ownership lock.
// Define LSU_ARB_LOCK_TIMEOUT_EN to bound lock ownership to MAX_LOCK consecutive cycles.
module lsu_arbiter #(
    parameter int MAX_LOCK = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_lock,
    input  logic [15:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_wr_en,
    input  logic [3:0]  m0_bmask,
    input  logic [2:0]  m0_ld_sel,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_lock,
    input  logic [15:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_wr_en,
    input  logic [3:0]  m1_bmask,
    input  logic [2:0]  m1_ld_sel,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic [15:0] lsu_addr,
    output logic [31:0] lsu_w_data,
    output logic        lsu_wr_en,
    output logic [3:0]  lsu_bmask,
    output logic [2:0]  lsu_ld_sel,
    input  logic [31:0] lsu_r_data,
    output logic        lock_tmo,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    // Handshake: a transfer happens in the cycle where mN_req and mN_gnt are both 1;
    // the read data for it appears on mN_rdata with mN_rvalid=1 one cycle later.

    state_e      state_q, state_d;
    logic        rr_q, rr_d;
    logic        m0_rvalid_q, m1_rvalid_q;
    logic [31:0] m0_rdata_q, m1_rdata_q;

    logic        own_act, own1;
    logic        sel_req, sel_lock, sel_wr, other_req, lock_eff;
    logic [15:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_bmask;
    logic [2:0]  sel_ld_sel;

    // MAX_LOCK must be at least 1; only the lock timeout build consumes it.
    if (MAX_LOCK < 1) begin : g_bad_max_lock
    end

    always_comb begin
        own_act    = (state_q != IDLE);
        own1       = (state_q == OWN1);
        sel_req    = own1 ? m1_req    : m0_req;
        sel_lock   = own1 ? m1_lock   : m0_lock;
        sel_wr     = own1 ? m1_wr_en  : m0_wr_en;
        sel_addr   = own1 ? m1_addr   : m0_addr;
        sel_wdata  = own1 ? m1_wdata  : m0_wdata;
        sel_bmask  = own1 ? m1_bmask  : m0_bmask;
        sel_ld_sel = own1 ? m1_ld_sel : m0_ld_sel;
        other_req  = own1 ? m0_req    : m1_req;
    end

    assign m0_gnt = (state_q == OWN0) && m0_req;
    assign m1_gnt = (state_q == OWN1) && m1_req;

    // The owner keeps its address on the bus between requests; a store only reaches
    // the LSU together with a grant.
    assign lsu_addr   = own_act ? sel_addr   : 16'h0000;
    assign lsu_w_data = own_act ? sel_wdata  : 32'h0000_0000;
    assign lsu_bmask  = own_act ? sel_bmask  : 4'h0;
    assign lsu_ld_sel = own_act ? sel_ld_sel : 3'b000;
    assign lsu_wr_en  = (m0_gnt || m1_gnt) && sel_wr;

`ifdef LSU_ARB_LOCK_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             tmo_hit, lock_tmo_q;

    assign tmo_hit  = own_act && sel_lock && (lock_cnt_q == CNT_W'(MAX_LOCK - 1));
    assign lock_eff = sel_lock && !tmo_hit;

    always_comb begin
        lock_cnt_d = lock_cnt_q + 1'b1;
        if (tmo_hit || !own_act || !sel_lock || (state_d != state_q)) begin
            lock_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lock_cnt_q <= '0;
            lock_tmo_q <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            lock_tmo_q <= tmo_hit;
        end
    end

    assign lock_tmo = lock_tmo_q;
`else
    assign lock_eff = sel_lock;
    assign lock_tmo = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (m0_req && m1_req) begin
                    state_d = rr_q ? OWN1 : OWN0;
                end else if (m0_req) begin
                    state_d = OWN0;
                end else if (m1_req) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (lock_eff) begin
                    state_d = state_q;
                end else if (other_req) begin
                    state_d = own1 ? OWN0 : OWN1;
                end else if (sel_req) begin
                    state_d = state_q;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Priority swings to the other master after every issued transaction.
    always_comb begin
        rr_d = rr_q;
        if (m0_gnt) rr_d = 1'b1;
        if (m1_gnt) rr_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= 32'h0000_0000;
            m1_rdata_q  <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            m0_rvalid_q <= m0_gnt;
            m1_rvalid_q <= m1_gnt;
            if (m0_gnt) m0_rdata_q <= lsu_r_data;
            if (m1_gnt) m1_rdata_q <= lsu_r_data;
        end
    end

    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed bench for lsu_arbiter: cycle vector table plus reset and lock-duration sequences.
// Covers LSU_ARB_LOCK_TIMEOUT_EN both defined and undefined.
module tb_lsu_arbiter;
  localparam int MAX_LOCK = 4;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_lock, m0_wr_en, m0_gnt, m0_rvalid;
  logic [15:0] m0_addr;
  logic [31:0] m0_wdata, m0_rdata;
  logic [3:0]  m0_bmask;
  logic [2:0]  m0_ld_sel;
  logic        m1_req, m1_lock, m1_wr_en, m1_gnt, m1_rvalid;
  logic [15:0] m1_addr;
  logic [31:0] m1_wdata, m1_rdata;
  logic [3:0]  m1_bmask;
  logic [2:0]  m1_ld_sel;
  logic [15:0] lsu_addr;
  logic [31:0] lsu_w_data, lsu_r_data;
  logic        lsu_wr_en;
  logic [3:0]  lsu_bmask;
  logic [2:0]  lsu_ld_sel;
  logic        lock_tmo;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wr_en(m0_wr_en), .m0_bmask(m0_bmask), .m0_ld_sel(m0_ld_sel),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wr_en(m1_wr_en), .m1_bmask(m1_bmask), .m1_ld_sel(m1_ld_sel),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .lsu_addr(lsu_addr), .lsu_w_data(lsu_w_data), .lsu_wr_en(lsu_wr_en),
    .lsu_bmask(lsu_bmask), .lsu_ld_sel(lsu_ld_sel), .lsu_r_data(lsu_r_data),
    .lock_tmo(lock_tmo), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // LSU model: word memory with combinational read, LEDR register at 0x4000
  logic [31:0] mem [0:63];
  bit   [63:0] mem_written;
  logic [31:0] io_ledr;
  bit          ledr_written;

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEAD_BEEF : 32'h1000_0000 + i;
  endfunction

  always_comb begin
    if (lsu_addr == 16'h4000) lsu_r_data = ledr_written ? io_ledr : 32'h0000_00FF;
    else if (mem_written[lsu_addr[7:2]]) lsu_r_data = mem[lsu_addr[7:2]];
    else lsu_r_data = init_word(int'(lsu_addr[7:2]));
  end

  always @(posedge clk) begin
    if (lsu_wr_en) begin
      if (lsu_addr == 16'h4000) begin
        io_ledr      <= lsu_w_data;
        ledr_written <= 1'b1;
      end else begin
        mem[lsu_addr[7:2]]         <= lsu_w_data;
        mem_written[lsu_addr[7:2]] <= 1'b1;
      end
    end
  end

  typedef struct {
    logic        rst_n;
    logic        req0, lock0, wr0;
    logic [15:0] addr0;
    logic        req1, lock1, wr1;
    logic [15:0] addr1;
    logic        gnt0, gnt1, rv0, rv1, wr;
    logic [15:0] laddr;
    logic [1:0]  st;
    logic        c0;
    logic [31:0] d0;
    logic        c1;
    logic [31:0] d1;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst_n, input logic r0, input logic l0, input logic w0,
                     input logic [15:0] a0, input logic r1, input logic l1, input logic w1,
                     input logic [15:0] a1, input logic g0, input logic g1, input logic v0,
                     input logic v1, input logic wr, input logic [15:0] la, input logic [1:0] st,
                     input logic c0, input logic [31:0] d0, input logic c1, input logic [31:0] d1);
    vec_t v;
    v.rst_n = rst_n; v.req0 = r0; v.lock0 = l0; v.wr0 = w0; v.addr0 = a0;
    v.req1 = r1; v.lock1 = l1; v.wr1 = w1; v.addr1 = a1;
    v.gnt0 = g0; v.gnt1 = g1; v.rv0 = v0; v.rv1 = v1; v.wr = wr; v.laddr = la; v.st = st;
    v.c0 = c0; v.d0 = d0; v.c1 = c1; v.d1 = d1;
    vecs.push_back(v);
  endtask

  // driver
  task automatic set_in(input logic r0, input logic l0, input logic w0, input logic [15:0] a0,
                        input logic r1, input logic l1, input logic w1, input logic [15:0] a1);
    m0_req = r0; m0_lock = l0; m0_wr_en = w0; m0_addr = a0; m0_wdata = 32'hA000_0000 | 32'(a0);
    m1_req = r1; m1_lock = l1; m1_wr_en = w1; m1_addr = a1; m1_wdata = 32'hB000_0000 | 32'(a1);
    m0_bmask = 4'hF; m0_ld_sel = 3'b010;
    m1_bmask = 4'hF; m1_ld_sel = 3'b010;
  endtask

  // scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    int g0_cnt, g1_cyc, tmo_cyc, g1_cnt, tmo_cnt;

    rst = 1'b0;
    set_in(0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst state", 32'(dbg_state), 32'(S_IDLE));
    check("rst gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
    check("rst rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    check("rst m0_rdata", m0_rdata, 32'd0);
    check("rst m1_rdata", m1_rdata, 32'd0);
    check("rst lsu_addr", 32'(lsu_addr), 32'd0);
    check("rst lsu_w_data", lsu_w_data, 32'd0);
    check("rst lsu_ctl", {24'd0, lsu_wr_en, lsu_bmask, lsu_ld_sel}, 32'd0);
    check("rst lock_tmo", 32'(lock_tmo), 32'd0);

    // rst  r0 l0 w0 a0        r1 l1 w1 a1        g0 g1 v0 v1 wr laddr     state   rd checks
    add(1, 1,0,0,16'h0010, 0,0,0,16'h0000, 0,0,0,0,0,16'h0000,S_IDLE, 0,0,0,0);
    add(1, 1,0,0,16'h0010, 0,0,0,16'h0000, 1,0,0,0,0,16'h0010,S_OWN0, 0,0,0,0);
    add(1, 0,0,0,16'h0010, 0,0,0,16'h0000, 0,0,1,0,0,16'h0010,S_OWN0, 1,32'hDEAD_BEEF,0,0);
    add(1, 0,0,0,16'h0010, 0,0,0,16'h0000, 0,0,0,0,0,16'h0000,S_IDLE, 0,0,0,0);
    add(0, 0,0,0,16'h0000, 0,0,0,16'h0000, 0,0,0,0,0,16'h0000,S_IDLE, 0,0,0,0);
    add(1, 1,0,0,16'h0020, 1,0,0,16'h0030, 0,0,0,0,0,16'h0000,S_IDLE, 0,0,0,0);
    add(1, 1,0,0,16'h0020, 1,0,0,16'h0030, 1,0,0,0,0,16'h0020,S_OWN0, 0,0,0,0);
    add(1, 1,0,0,16'h0020, 1,0,0,16'h0030, 0,1,1,0,0,16'h0030,S_OWN1, 1,32'h1000_0008,0,0);
    add(1, 1,0,0,16'h0020, 1,0,0,16'h0030, 1,0,0,1,0,16'h0020,S_OWN0, 0,0,1,32'h1000_000C);
    add(1, 1,0,0,16'h0020, 1,0,0,16'h0030, 0,1,1,0,0,16'h0030,S_OWN1, 1,32'h1000_0008,0,0);
    add(1, 0,0,0,16'h0020, 0,0,0,16'h0030, 0,0,0,1,0,16'h0020,S_OWN0, 0,0,1,32'h1000_000C);
    add(1, 0,0,0,16'h0000, 0,0,0,16'h0000, 0,0,0,0,0,16'h0000,S_IDLE, 0,0,0,0);
    add(1, 1,0,1,16'h0024, 0,0,0,16'h0000, 0,0,0,0,0,16'h0000,S_IDLE, 0,0,0,0);
    add(1, 1,0,1,16'h0024, 0,0,0,16'h0000, 1,0,0,0,1,16'h0024,S_OWN0, 0,0,0,0);
    add(1, 0,0,1,16'h0024, 0,0,0,16'h0000, 0,0,1,0,0,16'h0024,S_OWN0, 0,0,0,0);
    add(1, 0,0,0,16'h0000, 0,0,0,16'h0000, 0,0,0,0,0,16'h0000,S_IDLE, 0,0,0,0);
    add(1, 1,0,0,16'h0024, 0,0,0,16'h0000, 0,0,0,0,0,16'h0000,S_IDLE, 0,0,0,0);
    add(1, 1,0,0,16'h0024, 0,0,0,16'h0000, 1,0,0,0,0,16'h0024,S_OWN0, 0,0,0,0);
    add(1, 0,0,0,16'h0024, 0,0,0,16'h0000, 0,0,1,0,0,16'h0024,S_OWN0, 1,32'hA000_0024,0,0);
    add(1, 0,0,0,16'h0000, 0,0,0,16'h0000, 0,0,0,0,0,16'h0000,S_IDLE, 0,0,0,0);
    add(1, 1,0,0,16'h0010, 1,1,0,16'h4000, 0,0,0,0,0,16'h0000,S_IDLE, 0,0,0,0);
    add(1, 1,0,0,16'h0010, 1,1,0,16'h4000, 0,1,0,0,0,16'h4000,S_OWN1, 0,0,0,0);
    add(1, 1,0,0,16'h0010, 1,1,1,16'h4000, 0,1,0,1,1,16'h4000,S_OWN1, 0,0,1,32'h0000_00FF);
    add(1, 1,0,0,16'h0010, 0,0,0,16'h4000, 0,0,0,1,0,16'h4000,S_OWN1, 0,0,0,0);
    add(1, 1,0,0,16'h0010, 0,0,0,16'h0000, 1,0,0,0,0,16'h0010,S_OWN0, 0,0,0,0);
    add(1, 0,0,0,16'h0010, 0,0,0,16'h0000, 0,0,1,0,0,16'h0010,S_OWN0, 1,32'hDEAD_BEEF,0,0);
    add(1, 0,0,0,16'h0000, 0,0,0,16'h0000, 0,0,0,0,0,16'h0000,S_IDLE, 0,0,0,0);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst = vecs[i].rst_n;
      set_in(vecs[i].req0, vecs[i].lock0, vecs[i].wr0, vecs[i].addr0,
             vecs[i].req1, vecs[i].lock1, vecs[i].wr1, vecs[i].addr1);
      @(negedge clk);
      check($sformatf("v%0d m0_gnt", i), 32'(m0_gnt), 32'(vecs[i].gnt0));
      check($sformatf("v%0d m1_gnt", i), 32'(m1_gnt), 32'(vecs[i].gnt1));
      check($sformatf("v%0d m0_rvalid", i), 32'(m0_rvalid), 32'(vecs[i].rv0));
      check($sformatf("v%0d m1_rvalid", i), 32'(m1_rvalid), 32'(vecs[i].rv1));
      check($sformatf("v%0d lsu_wr_en", i), 32'(lsu_wr_en), 32'(vecs[i].wr));
      check($sformatf("v%0d lsu_addr", i), 32'(lsu_addr), 32'(vecs[i].laddr));
      check($sformatf("v%0d state", i), 32'(dbg_state), 32'(vecs[i].st));
      check($sformatf("v%0d lock_tmo", i), 32'(lock_tmo), 32'd0);
      if (vecs[i].c0) check($sformatf("v%0d m0_rdata", i), m0_rdata, vecs[i].d0);
      if (vecs[i].c1) check($sformatf("v%0d m1_rdata", i), m1_rdata, vecs[i].d1);
    end
    check("ledr after m1 store", io_ledr, 32'hB000_4000);

    // reset sampled at the end of a grant cycle: rvalid must never appear
    @(posedge clk); #1;
    set_in(0, 0, 0, 16'h0, 1, 0, 0, 16'h0030);
    @(negedge clk);
    check("rstmid idle", 32'(dbg_state), 32'(S_IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid gnt1", 32'(m1_gnt), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    set_in(1, 0, 0, 16'h0010, 1, 0, 0, 16'h0030);
    @(negedge clk);
    check("rstmid m1_rvalid", 32'(m1_rvalid), 32'd0);
    check("rstmid m1_rdata", m1_rdata, 32'd0);
    check("rstmid m0_rdata", m0_rdata, 32'd0);
    check("rstmid state", 32'(dbg_state), 32'(S_IDLE));
    check("rstmid lsu", {lsu_addr, 7'd0, lsu_wr_en, lsu_bmask, lsu_ld_sel, 1'b0}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstmid first gnt m0", {30'd0, m1_gnt, m0_gnt}, 32'd1);
    check("rstmid lsu_w_data", lsu_w_data, 32'hA000_0010);
    @(posedge clk); #1;
    rst = 1'b0;
    set_in(0, 0, 0, 16'h0, 0, 0, 0, 16'h0);

    // m0 holds its lock while m1 keeps requesting
    @(posedge clk); #1;
    rst = 1'b1;
    set_in(1, 1, 0, 16'h0010, 1, 0, 0, 16'h0030);
    g0_cnt = 0; g1_cyc = -1; tmo_cyc = -1; g1_cnt = 0; tmo_cnt = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (m1_gnt) begin
        g1_cnt++;
        if (g1_cyc < 0) g1_cyc = k;
      end
      if (lock_tmo) begin
        tmo_cnt++;
        if (tmo_cyc < 0) tmo_cyc = k;
      end
      if (m0_gnt && g1_cyc < 0) g0_cnt++;
    end
`ifdef LSU_ARB_LOCK_TIMEOUT_EN
    check("tmo locked grants", 32'(g0_cnt), 32'(MAX_LOCK));
    check("tmo pulse cycle", 32'(tmo_cyc), 32'(MAX_LOCK + 1));
    check("tmo m1 gnt after pulse", 32'((g1_cyc >= tmo_cyc) && (g1_cyc <= tmo_cyc + 1)), 32'd1);
`else
    check("lock m0 grants", 32'(g0_cnt), 32'd23);
    check("lock m1 starved", 32'(g1_cnt), 32'd0);
    check("lock no tmo", 32'(tmo_cnt), 32'd0);
`endif
    @(posedge clk); #1;
    set_in(0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
